// File: rtl/bcd_seg_scan_pkg.sv
// ---------------------------------------------------------------------------
// bcd_seg_scan_pkg
//   Shared constants and helpers for the multiplexed 7-segment display
//   stage that sits behind the binary-to-BCD converter.
//
//   Contents:
//     NUM_DIGITS    number of display positions (5 magnitude digits + sign)
//     IDX_W         width of the digit scan index
//     MAG_W         width of the packed BCD magnitude
//     SEG_*         active-low segment patterns, bit order {g,f,e,d,c,b,a}
//     disp_word_t   sign + packed BCD magnitude as held for one frame
//     scan_an()     active-low anode pattern for a scan index
//     upper_mag()   magnitude with the digits below position k shifted out
// ---------------------------------------------------------------------------
package bcd_seg_scan_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int MAG_DIGITS = NUM_DIGITS - 1;
  localparam int MAG_W      = 4 * MAG_DIGITS;
  localparam int IDX_W      = 3;

  localparam logic [IDX_W-1:0] IDX_SIGN = IDX_W'(NUM_DIGITS - 1);

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_E    = 7'b0000110;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;

  // One displayable value: the sign sits above the packed BCD digits so the
  // struct packs to exactly {neg, bcd_in}.
  typedef struct packed {
    logic             neg;
    logic [MAG_W-1:0] mag;
  } disp_word_t;

  // Active-low one-cold anode pattern for scan position idx.
  function automatic logic [NUM_DIGITS-1:0] scan_an(input logic [IDX_W-1:0] idx);
    logic [NUM_DIGITS-1:0] onehot;
    onehot = NUM_DIGITS'(1) << idx;
    return ~onehot;
  endfunction

  // Digits at and above position k, shifted down to the bottom. A result of
  // zero means position k is a leading zero.
  function automatic logic [MAG_W-1:0] upper_mag(input logic [MAG_W-1:0] mag,
                                                 input logic [IDX_W-1:0] k);
    return mag >> (4 * k);
  endfunction

endpackage

// File: rtl/bcd_seg_scan_bcd_to_seg.sv
// ---------------------------------------------------------------------------
// bcd_to_seg
//   Combinational BCD digit to 7-segment decoder for a common-anode display.
//
//   Ports:
//     digit  in   4-bit BCD digit
//     seg    out  active-low segment pattern {g,f,e,d,c,b,a}; codes above 9
//                 show "E" so a corrupted nibble is visible on the display
// ---------------------------------------------------------------------------
module bcd_to_seg
  import bcd_seg_scan_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_E;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// ---------------------------------------------------------------------------
// bcd_seg_scan
//   Display stage behind the binary-to-BCD converter. Scans a signed 5-digit
//   BCD value onto a 6-position multiplexed common-anode 7-segment display
//   (sign position + 5 magnitude digits).
//
//   A captured value waits in a pending register and is only copied into the
//   display register at a frame boundary, so one full scan never mixes two
//   values. Each position is lit for CLK_DIV clocks with no gap between
//   positions.
//
//   Parameters:
//     CLK_DIV      clk cycles per digit slot (>= 1)
//
//   Ports:
//     clk          system clock
//     rst          synchronous active-high reset
//     bcd_in       packed BCD, [19:16] ten-thousands .. [3:0] ones
//     neg          sign of bcd_in, 1 = negative
//     bcd_valid    single-cycle strobe capturing bcd_in/neg
//     blank_en     1 = blank leading zeros (ones digit always shown)
//     an           active-low digit enables, an[0] ones .. an[4]
//                  ten-thousands, an[5] sign
//     seg          active-low segments {g,f,e,d,c,b,a}
//     frame_start  one-cycle pulse on the cycle the display register reloads
// ---------------------------------------------------------------------------
module bcd_seg_scan
  import bcd_seg_scan_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MAG_W-1:0]      bcd_in,
  input  logic                  neg,
  input  logic                  bcd_valid,
  input  logic                  blank_en,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  frame_start
);

  localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0]      cnt_p0;
  logic [IDX_W-1:0]      idx_p0;
  logic                  tick_p0;
  logic                  frame_tick_p0;

  disp_word_t            pending_p0;
  logic                  pend_vld_p0;
  disp_word_t            disp_p0;

  logic [3:0]            nibble_p0;
  logic [6:0]            dec_seg_p0;
  logic                  lead_zero_p0;
  logic [NUM_DIGITS-1:0] an_nxt_p0;
  logic [6:0]            seg_nxt_p0;

  logic [NUM_DIGITS-1:0] an_p1;
  logic [6:0]            seg_p1;
  logic                  frame_start_p1;

  // ---- stage p0: prescaler, scan index, capture and frame-coherent load ----
  assign tick_p0       = (cnt_p0 == CNT_LAST);
  assign frame_tick_p0 = tick_p0 && (idx_p0 == IDX_SIGN);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0 <= '0;
      idx_p0 <= '0;
    end else begin
      // With CLK_DIV == 1, CNT_LAST is 0 so tick holds high and cnt stays 0.
      cnt_p0 <= tick_p0 ? '0 : cnt_p0 + CNT_W'(1);
      if (tick_p0) begin
        idx_p0 <= (idx_p0 == IDX_SIGN) ? '0 : idx_p0 + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_p0  <= '0;
      pend_vld_p0 <= 1'b0;
      disp_p0     <= '0;
    end else begin
      // The boundary load uses the pending value from before this edge; a
      // strobe on the same edge refills pending and keeps it flagged for the
      // following frame.
      if (frame_tick_p0 && pend_vld_p0) begin
        disp_p0 <= pending_p0;
      end
      if (bcd_valid) begin
        pending_p0  <= '{neg: neg, mag: bcd_in};
        pend_vld_p0 <= 1'b1;
      end else if (frame_tick_p0) begin
        pend_vld_p0 <= 1'b0;
      end
    end
  end

  // Digit select and decode. The sign slot (idx 5) shifts the magnitude out
  // completely, so the decoder sees 0 there and its output is ignored.
  assign nibble_p0 = upper_mag(disp_p0.mag, idx_p0)[3:0];

  bcd_to_seg u_bcd_to_seg (
    .digit (nibble_p0),
    .seg   (dec_seg_p0)
  );

  // A position is a leading zero when it and every digit above it are zero.
  // blank_en is used live so toggling it takes effect on the next slot.
  assign lead_zero_p0 = blank_en && (idx_p0 != '0) &&
                        (upper_mag(disp_p0.mag, idx_p0) == '0);

  always_comb begin
    an_nxt_p0  = scan_an(idx_p0);
    seg_nxt_p0 = dec_seg_p0;
    if (idx_p0 == IDX_SIGN) begin
      seg_nxt_p0 = disp_p0.neg ? SEG_DASH : SEG_OFF;
    end else if (lead_zero_p0) begin
      seg_nxt_p0 = SEG_OFF;
    end
  end

  // ---- stage p1: registered display drive (lags idx by one cycle) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      an_p1          <= AN_OFF;
      seg_p1         <= SEG_OFF;
      frame_start_p1 <= 1'b0;
    end else begin
      an_p1          <= an_nxt_p0;
      seg_p1         <= seg_nxt_p0;
      frame_start_p1 <= frame_tick_p0;
    end
  end

  assign an          = an_p1;
  assign seg         = seg_p1;
  assign frame_start = frame_start_p1;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// ---------------------------------------------------------------------------
// tb_bcd_seg_scan
//   Self-checking bench for bcd_seg_scan with CLK_DIV = 4. A reference model
//   derives the scan position from the number of clocks since reset and
//   keeps the pending/displayed values as plain variables; every clock the
//   DUT outputs are compared with it. Directed scenarios add fixed expected
//   patterns, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_bcd_seg_scan;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] bcd_in;
  logic        neg;
  logic        bcd_valid;
  logic        blank_en;
  logic [5:0]  an;
  logic [6:0]  seg;
  logic        frame_start;

  bcd_seg_scan #(.CLK_DIV(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .bcd_in      (bcd_in),
    .neg         (neg),
    .bcd_valid   (bcd_valid),
    .blank_en    (blank_en),
    .an          (an),
    .seg         (seg),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: clocks since reset, pending and displayed value.
  int          m_n;
  logic [20:0] m_pend;
  logic [20:0] m_disp;
  bit          m_pflag;
  logic [5:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_fs;

  logic [6:0] seg_tab [0:9];
  logic [5:0] s1_an   [0:5];
  logic [6:0] s1_seg  [0:5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_idx();
    return (m_n / D) % 6;
  endfunction

  function automatic int m_cnt();
    return m_n % D;
  endfunction

  // Expected pattern for display position pos given the displayed value.
  function automatic logic [6:0] ref_seg(input int pos, input logic [20:0] d, input bit blank);
    bit all_zero;
    int dig;
    if (pos == 5) return d[20] ? 7'b0111111 : 7'b1111111;
    all_zero = 1'b1;
    for (int k = pos; k < 5; k++)
      if (d[4*k +: 4] != 4'd0) all_zero = 1'b0;
    if (blank && pos > 0 && all_zero) return 7'b1111111;
    dig = int'(d[4*pos +: 4]);
    if (dig > 9) return 7'b0000110;
    return seg_tab[dig];
  endfunction

  // Advance one clock: update the model from the inputs now applied, then
  // compare the DUT outputs #1 after the edge.
  task automatic step();
    int  idx;
    bit  bnd;
    if (rst) begin
      m_n = 0; m_pend = '0; m_pflag = 1'b0; m_disp = '0;
      e_an = 6'b111111; e_seg = 7'b1111111; e_fs = 1'b0;
    end else begin
      idx   = m_idx();
      bnd   = (m_cnt() == D-1) && (idx == 5);
      e_an  = 6'(~(6'd1 << idx));
      e_seg = ref_seg(idx, m_disp, blank_en);
      e_fs  = bnd;
      if (bnd && m_pflag) m_disp = m_pend;
      if (bcd_valid) begin
        m_pend  = {neg, bcd_in};
        m_pflag = 1'b1;
      end else if (bnd) begin
        m_pflag = 1'b0;
      end
      m_n++;
    end
    @(posedge clk);
    #1;
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
  endtask

  task automatic strobe(input logic [19:0] v, input logic s);
    bcd_in = v; neg = s; bcd_valid = 1'b1;
    step();
    bcd_valid = 1'b0;
  endtask

  task automatic wait_fs();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      step();
      if (frame_start === 1'b1) got = 1'b1;
    end
    chk("wait_frame_start", 32'(got), 32'd1);
  endtask

  task automatic wait_idx(input int target);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (m_idx() == target) got = 1'b1;
      else step();
    end
    chk("wait_idx", 32'(got), 32'd1);
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    s1_an[0] = 6'b111110; s1_seg[0] = 7'b1111000;
    s1_an[1] = 6'b111101; s1_seg[1] = 7'b0100100;
    s1_an[2] = 6'b111011; s1_seg[2] = 7'b1111001;
    s1_an[3] = 6'b110111; s1_seg[3] = 7'b1111111;
    s1_an[4] = 6'b101111; s1_seg[4] = 7'b1111111;
    s1_an[5] = 6'b011111; s1_seg[5] = 7'b0111111;

    rst = 1'b1; bcd_in = '0; neg = 1'b0; bcd_valid = 1'b0; blank_en = 1'b1;
    step();
    step();
    chk("reset_an", 32'(an), 32'h3f);
    chk("reset_seg", 32'(seg), 32'h7f);
    chk("reset_fs", 32'(frame_start), 32'd0);
    rst = 1'b0;

    // Scenario 1: -127 with blanking, one full frame held 4 cycles per slot.
    strobe(20'h00127, 1'b1);
    wait_fs();
    for (int j = 0; j < 24; j++) begin
      step();
      chk("s1_an", 32'(an), 32'(s1_an[j/4]));
      chk("s1_seg", 32'(seg), 32'(s1_seg[j/4]));
    end

    // Scenario 2: zero, blanking on then off.
    strobe(20'h00000, 1'b0);
    wait_fs();
    for (int j = 0; j < 24; j++) begin
      step();
      chk("s2_blank", 32'(seg), (j < 4) ? 32'h40 : 32'h7f);
    end
    blank_en = 1'b0;
    for (int j = 0; j < 24; j++) begin
      step();
      chk("s2_noblank", 32'(seg), (j < 20) ? 32'h40 : 32'h7f);
    end
    blank_en = 1'b1;

    // Scenario 3: two strobes in one frame, last one wins.
    wait_idx(2);
    strobe(20'h00005, 1'b0);
    wait_idx(4);
    strobe(20'h00009, 1'b0);
    chk("s3_hold", 32'(seg), 32'h7f);
    wait_fs();
    step();
    chk("s3_d0", 32'(seg), 32'b0010000);

    // Scenario 4: strobe on the boundary tick while 3 is pending.
    strobe(20'h00003, 1'b0);
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
        if (m_idx() == 5 && m_cnt() == D-1) got = 1'b1;
        else step();
      end
      chk("s4_find_boundary", 32'(got), 32'd1);
    end
    strobe(20'h00008, 1'b0);
    chk("s4_fs", 32'(frame_start), 32'd1);
    step();
    chk("s4_shows3", 32'(seg), 32'b0110000);
    wait_fs();
    step();
    chk("s4_shows8", 32'(seg), 32'b0000000);

    // Scenario 5: non-decimal nibble shows E.
    strobe(20'h0000A, 1'b0);
    wait_fs();
    step();
    chk("s5_E", 32'(seg), 32'b0000110);

    // Scenario 6: reset mid-scan discards the pending value.
    strobe(20'h00042, 1'b1);
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    chk("s6_rst_an", 32'(an), 32'h3f);
    chk("s6_rst_seg", 32'(seg), 32'h7f);
    chk("s6_rst_fs", 32'(frame_start), 32'd0);
    rst = 1'b0;
    step();
    chk("s6_first_an", 32'(an), 32'b111110);
    chk("s6_first_seg", 32'(seg), 32'b1000000);
    for (int i = 0; i < 48; i++) step();

    // Randomized traffic.
    for (int i = 0; i < 900; i++) begin
      logic [19:0] v;
      int keep;
      for (int k = 0; k < 5; k++) v[4*k +: 4] = 4'($urandom_range(0, 11));
      keep = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 1) v = v & 20'((64'd1 << (4*keep)) - 1);
      rst       = ($urandom_range(0, 249) == 0);
      bcd_valid = ($urandom_range(0, 9) == 0);
      bcd_in    = v;
      neg       = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) blank_en = ~blank_en;
      step();
    end
    rst = 1'b0; bcd_valid = 1'b0;
    for (int i = 0; i < 30; i++) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
